mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates one single-ported RAM between the instruction-fetch requester and the data-access requester.
- Sits between the datapath/caches and the RAM model. Each requester sees a wait/load handshake; the RAM sees one request stream.
- Data has priority. A starvation counter forces an instruction grant after a configurable run of consecutive data grants.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before instruction gets forced priority; legal range 1..15.
- WORD_W, 32: address and data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request; held until iwait is low.
- iaddr  in  WORD_W  instruction address; stable while iREN is high.
- iwait  out  1  instruction not yet serviced.
- iload  out  WORD_W  instruction read data; valid only when iREN=1 and iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  data write value.
- dwait  out  1  data access not yet serviced.
- dload  out  WORD_W  data read value; valid when dREN=1 and dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- ram_err  out  1  one-cycle pulse when ramstate=ERROR during a grant.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, starve_cnt=0, ram_err=0;
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- While RST is high, iwait=iREN and dwait=(dREN|dWEN).
- FSM states: IDLE, IGRANT, DGRANT. State is registered; RAM outputs are combinational from state plus the granted requester's live inputs.
- IDLE:
  - No RAM strobes driven.
  - Arbitration for the next cycle:
    - if iREN=1 and starve_cnt==STARVE_MAX, go to IGRANT;
    - else if dREN|dWEN, go to DGRANT;
    - else if iREN, go to IGRANT;
    - else stay in IDLE.
- IGRANT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0, iload=ramload for that cycle, next state IDLE.
- DGRANT:
  - ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are asserted), ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0, dload=ramload, next state IDLE.
- Wait outputs are otherwise high whenever the matching request is high; they are low when no request is present.
- Load outputs are 0 when their completion condition is not met.
- Minimum latency: request seen in IDLE at cycle N, grant at N+1, completion at N+1 if RAM returns ACCESS immediately. Back-to-back accesses therefore cost ≥2 cycles each.
- starve_cnt, updated on each DGRANT completion:
  - increments if iREN=1, saturating at STARVE_MAX;
  - clears to 0 if iREN=0;
  - clears to 0 on any IGRANT completion.
- Abort: if the granted requester drops its request before ACCESS, all RAM strobes go low the same cycle and the next state is IDLE. No completion is counted.
- ERROR while granted:
  - ram_err=1 for one cycle, wait stays high, next state IDLE;
  - the request re-arbitrates, so the access is retried;
  - starve_cnt is unchanged.
- BUSY/FREE while granted: hold the state and keep the strobes.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_MAX: data wins. The instruction waits and iwait stays high throughout.
- A request that arrives in the same cycle another completes is seen in IDLE on the following cycle; no grant ever skips IDLE.

Test Plan:
- Reset mid-DGRANT (RST high while ramstate=BUSY) -> state IDLE, ramWEN=ramREN=0, ram_err=0 that cycle; after RST low, a held dWEN is re-granted 1 cycle later.
- Lone iREN, iaddr=0x0000_0040, RAM returns ACCESS on the first grant cycle with ramload=0x2008_0001 -> ramREN=1 and ramaddr=0x40 on cycle 1; iwait=0 and iload=0x2008_0001 on cycle 1; IDLE on cycle 2.
- Simultaneous iREN and dWEN (daddr=0x100, dstore=0xDEAD_BEEF), RAM has 2 BUSY cycles then ACCESS -> data served first (ramWEN=1, ramstore=0xDEADBEEF, dwait low on cycle 3); iREN granted on cycle 5.
- Starvation with STARVE_MAX=4, iREN and dREN held continuously, RAM always ACCESS -> grant order D,D,D,D,I,D…; starve_cnt reads 4 before the I grant and 0 after it.
- Abort: DGRANT active, dREN dropped while ramstate=BUSY -> ramREN=0 the same cycle, IDLE next cycle, starve_cnt unchanged; a pending iREN is granted the cycle after.
- ERROR: IGRANT with ramstate=3 -> ram_err pulses 1 cycle, iwait stays 1, IDLE, then IGRANT again; the next ACCESS completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data access.
// Data has priority; a starvation counter forces an instruction grant after a run of data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int WORD_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, next_state;
  logic [3:0] starve_cnt, next_starve;
  logic       dreq, ram_access, ram_error;

  assign dreq       = dREN | dWEN;
  assign ram_access = (ramstate == RAM_ACCESS);
  assign ram_error  = (ramstate == RAM_ERROR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_starve;
    end
  end

  // A grant whose requester has dropped out drives nothing and falls back to IDLE.
  always_comb begin
    next_state  = state;
    next_starve = starve_cnt;
    iwait       = iREN;
    dwait       = dreq;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    ram_err     = 1'b0;

    unique case (state)
      IDLE: begin
        if (iREN && (starve_cnt == STARVE_LIM)) next_state = IGRANT;
        else if (dreq)                           next_state = DGRANT;
        else if (iREN)                           next_state = IGRANT;
        else                                     next_state = IDLE;
      end

      IGRANT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_access) begin
            iwait       = 1'b0;
            iload       = ramload;
            next_state  = IDLE;
            next_starve = 4'd0;
          end else if (ram_error) begin
            ram_err    = 1'b1;
            next_state = IDLE;
          end
        end
      end

      DGRANT: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_access) begin
            dwait      = 1'b0;
            dload      = ramload;
            next_state = IDLE;
            if (!iREN)                    next_starve = 4'd0;
            else if (starve_cnt < STARVE_LIM) next_starve = starve_cnt + 4'd1;
          end else if (ram_error) begin
            ram_err    = 1'b1;
            next_state = IDLE;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule
